// File: rtl/r2b_pkg.sv
// Shared constants, state encoding and parameter checks for the row-to-block converter.
package r2b_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } r2b_state_e;

  function automatic int unsigned calc_nc(input int unsigned cores_h, input int unsigned cores_v);
    return cores_h * cores_v;
  endfunction

  function automatic int unsigned calc_band_rows(input int unsigned block_size,
                                                 input int unsigned cores_v);
    return block_size * cores_v;
  endfunction

  function automatic int unsigned calc_beats_per_band(input int unsigned col,
                                                      input int unsigned block_size,
                                                      input int unsigned cores_h);
    return col / (block_size * cores_h);
  endfunction

  function automatic int unsigned calc_bands(input int unsigned row,
                                             input int unsigned block_size,
                                             input int unsigned cores_v);
    return row / (block_size * cores_v);
  endfunction

  // Index width that stays at least one bit for degenerate single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned frac_width,
                                      input int unsigned row, input int unsigned col,
                                      input int unsigned block_size,
                                      input int unsigned chunk_size,
                                      input int unsigned cores_h, input int unsigned cores_v);
    if (width == 0 || block_size == 0 || cores_h == 0 || cores_v == 0) return 1'b0;
    if (row == 0 || col == 0) return 1'b0;
    if (frac_width > width) return 1'b0;
    if (chunk_size != block_size * block_size) return 1'b0;
    if (row % (block_size * cores_v) != 0) return 1'b0;
    if (col % (block_size * cores_h) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/r2b_band_buffer.sv
// Ping-pong band storage: one bank fills row by row while the other is drained.
// A completed band becomes visible to the reader one edge after its last row lands.
module r2b_band_buffer #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned COL       = 64,
  parameter int unsigned BAND_ROWS = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic                           write_row,
  input  logic [WIDTH*COL-1:0]           write_data,
  output logic                           write_full,
  output logic                           write_last,
  input  logic                           commit,
  output logic                           read_full,
  output logic [BAND_ROWS*WIDTH*COL-1:0] read_rows
);
  import r2b_pkg::*;

  localparam int unsigned RowW    = WIDTH * COL;
  localparam int unsigned RowIdxW = idx_width(BAND_ROWS);

  logic [RowW-1:0]    mem_q [2][BAND_ROWS];
  logic [RowW-1:0]    mem_d [2][BAND_ROWS];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [RowIdxW-1:0] wr_row_q, wr_row_d;
  logic               pend_q, pend_d;
  logic               pend_bank_q, pend_bank_d;

  assign write_full = full_q[wr_bank_q];
  assign write_last = (wr_row_q == RowIdxW'(BAND_ROWS - 1));
  assign read_full  = full_q[rd_bank_q];

  // Row storage next state: only the addressed row of the write bank changes.
  always_comb begin
    mem_d = mem_q;
    if (en && write_row) mem_d[wr_bank_q][wr_row_q] = write_data;
  end

  // Pointer and full-flag next state; a bank is never committed while it is being set full.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_row_d    = wr_row_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    if (en) begin
      if (pend_q) begin
        full_d[pend_bank_q] = 1'b1;
        pend_d              = 1'b0;
      end
      if (write_row) begin
        if (write_last) begin
          wr_row_d    = '0;
          wr_bank_d   = ~wr_bank_q;
          pend_d      = 1'b1;
          pend_bank_d = wr_bank_q;
        end else begin
          wr_row_d = wr_row_q + RowIdxW'(1);
        end
      end
      if (commit) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  // Present the whole read bank; row r sits at the r-th RowW slice.
  always_comb begin
    read_rows = '0;
    for (int unsigned r = 0; r < BAND_ROWS; r++) begin
      read_rows[r*RowW +: RowW] = mem_q[rd_bank_q][r];
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_row_q    <= '0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_row_q    <= wr_row_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
    end
  end

  // Row storage; contents are don't-care until their full flag is set, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/r2b_converter.sv
// Row-ordered matrix in, block-ordered beats out: one BLOCK_SIZE x BLOCK_SIZE block per core.
module r2b_converter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned FRAC_WIDTH  = 8,
  parameter int unsigned ROW         = 256,
  parameter int unsigned COL         = 64,
  parameter int unsigned BLOCK_SIZE  = 2,
  parameter int unsigned CHUNK_SIZE  = 4,
  parameter int unsigned NUM_CORES_H = 2,
  parameter int unsigned NUM_CORES_V = 2
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                en,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic [WIDTH*COL-1:0]                                in_data,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [WIDTH*CHUNK_SIZE*NUM_CORES_H*NUM_CORES_V-1:0] out_data,
  output logic                                                out_band_last,
  output logic                                                out_last,
  output logic                                                done
);
  import r2b_pkg::*;

  localparam int unsigned NC       = calc_nc(NUM_CORES_H, NUM_CORES_V);
  localparam int unsigned BandRows = calc_band_rows(BLOCK_SIZE, NUM_CORES_V);
  localparam int unsigned Bpb      = calc_beats_per_band(COL, BLOCK_SIZE, NUM_CORES_H);
  localparam int unsigned Bands    = calc_bands(ROW, BLOCK_SIZE, NUM_CORES_V);
  localparam int unsigned RowW     = WIDTH * COL;
  localparam int unsigned OutW     = WIDTH * CHUNK_SIZE * NC;
  localparam int unsigned ColIdxW  = idx_width(Bpb);
  localparam int unsigned BandCntW = $clog2(Bands + 1);

  if (!params_legal(WIDTH, FRAC_WIDTH, ROW, COL, BLOCK_SIZE, CHUNK_SIZE, NUM_CORES_H,
                    NUM_CORES_V)) begin : g_bad_params
    $error("r2b_converter: illegal parameter combination");
  end

  r2b_state_e          state_q, state_d;
  logic [ColIdxW-1:0]  rd_col_q, rd_col_d;
  logic [BandCntW-1:0] bands_written_q, bands_written_d;
  logic [BandCntW-1:0] bands_read_q, bands_read_d;
  logic                out_valid_q, out_valid_d;
  logic                out_band_last_q, out_band_last_d;
  logic                out_last_q, out_last_d;
  logic [OutW-1:0]     out_data_q, out_data_d;

  logic                   wr_full;
  logic                   wr_last_row;
  logic                   rd_full;
  logic                   accept;
  logic                   load;
  logic                   beat_last;
  logic [BandRows*RowW-1:0] rd_rows;
  logic [OutW-1:0]        beat_data;

  assign in_ready  = en && (state_q == StRun) && !wr_full &&
                     (bands_written_q < BandCntW'(Bands));
  assign accept    = in_valid && in_ready;
  assign load      = en && rd_full && (!out_valid_q || out_ready);
  assign beat_last = (rd_col_q == ColIdxW'(Bpb - 1));

  r2b_band_buffer #(
    .WIDTH     (WIDTH),
    .COL       (COL),
    .BAND_ROWS (BandRows)
  ) u_band_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .write_row  (accept),
    .write_data (in_data),
    .write_full (wr_full),
    .write_last (wr_last_row),
    .commit     (load && beat_last),
    .read_full  (rd_full),
    .read_rows  (rd_rows)
  );

  // Gather block slots for the current column group from the buffered band.
  always_comb begin
    int unsigned k, e, r, c, col_base;
    beat_data = '0;
    col_base  = 32'(rd_col_q) * BLOCK_SIZE * NUM_CORES_H;
    for (int unsigned v = 0; v < NUM_CORES_V; v++) begin
      for (int unsigned h = 0; h < NUM_CORES_H; h++) begin
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
          for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
            k = v * NUM_CORES_H + h;
            e = i * BLOCK_SIZE + j;
            r = v * BLOCK_SIZE + i;
            c = col_base + h * BLOCK_SIZE + j;
            beat_data[((NC-1-k)*CHUNK_SIZE + (CHUNK_SIZE-1-e))*WIDTH +: WIDTH] =
                rd_rows[r*RowW + (COL-1-c)*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  // FSM next state: finish once the matrix-final beat is handed off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (en) state_d = StRun;
      StRun:   if (en && out_valid_q && out_ready && out_last_q) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Band counters and the registered output stage.
  always_comb begin
    bands_written_d = bands_written_q;
    bands_read_d    = bands_read_q;
    rd_col_d        = rd_col_q;
    out_valid_d     = out_valid_q;
    out_band_last_d = out_band_last_q;
    out_last_d      = out_last_q;
    out_data_d      = out_data_q;
    if (accept && wr_last_row) bands_written_d = bands_written_q + BandCntW'(1);
    if (load) begin
      out_valid_d     = 1'b1;
      out_data_d      = beat_data;
      out_band_last_d = beat_last;
      out_last_d      = beat_last && (bands_read_q == BandCntW'(Bands - 1));
      if (beat_last) begin
        rd_col_d     = '0;
        bands_read_d = bands_read_q + BandCntW'(1);
      end else begin
        rd_col_d = rd_col_q + ColIdxW'(1);
      end
    end else if (en && out_ready) begin
      out_valid_d     = 1'b0;
      out_band_last_d = 1'b0;
      out_last_d      = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      rd_col_q        <= '0;
      bands_written_q <= '0;
      bands_read_q    <= '0;
      out_valid_q     <= 1'b0;
      out_band_last_q <= 1'b0;
      out_last_q      <= 1'b0;
      out_data_q      <= '0;
    end else begin
      state_q         <= state_d;
      rd_col_q        <= rd_col_d;
      bands_written_q <= bands_written_d;
      bands_read_q    <= bands_read_d;
      out_valid_q     <= out_valid_d;
      out_band_last_q <= out_band_last_d;
      out_last_q      <= out_last_d;
      out_data_q      <= out_data_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_band_last = out_band_last_q;
  assign out_last      = out_last_q;
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_r2b_converter.sv
// Bench for r2b_converter on an 8x8 matrix, 2x2 blocks, 2x2 cores.
module tb_r2b_converter;

  localparam int W     = 16;
  localparam int NROW  = 8;
  localparam int NCOL  = 8;
  localparam int NBEAT = 4;
  localparam int OUTW  = 256;

  localparam logic [OUTW-1:0] Lit0 = {16'h00, 16'h01, 16'h10, 16'h11, 16'h02, 16'h03, 16'h12,
                                      16'h13, 16'h20, 16'h21, 16'h30, 16'h31, 16'h22, 16'h23,
                                      16'h32, 16'h33};
  localparam logic [OUTW-1:0] Lit1 = {16'h04, 16'h05, 16'h14, 16'h15, 16'h06, 16'h07, 16'h16,
                                      16'h17, 16'h24, 16'h25, 16'h34, 16'h35, 16'h26, 16'h27,
                                      16'h36, 16'h37};
  localparam logic [OUTW-1:0] Lit2 = {16'h40, 16'h41, 16'h50, 16'h51, 16'h42, 16'h43, 16'h52,
                                      16'h53, 16'h60, 16'h61, 16'h70, 16'h71, 16'h62, 16'h63,
                                      16'h72, 16'h73};

  typedef struct packed {
    logic [OUTW-1:0] data;
    logic            band_last;
    logic            last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W*NCOL-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [OUTW-1:0]   out_data;
  logic              out_band_last;
  logic              out_last;
  logic              done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int beats_seen = 0;
  int rows_acc = 0;
  int first_valid_edge = -1;
  int acc_edge [NROW];

  logic [W-1:0]    mat [NROW][NCOL];
  beat_t           exp_q [$];
  beat_t           cmp_e;
  logic [OUTW-1:0] first_data;
  logic [OUTW-1:0] prev_data;
  logic            hold_prev = 1'b0;
  logic [OUTW-1:0] snap;

  r2b_converter #(
    .WIDTH       (16),
    .FRAC_WIDTH  (8),
    .ROW         (8),
    .COL         (8),
    .BLOCK_SIZE  (2),
    .CHUNK_SIZE  (4),
    .NUM_CORES_H (2),
    .NUM_CORES_V (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_band_last (out_band_last),
    .out_last      (out_last),
    .done          (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [OUTW-1:0] act,
                       input logic [OUTW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_matrix(input bit rnd);
    for (int r = 0; r < NROW; r++)
      for (int c = 0; c < NCOL; c++)
        mat[r][c] = rnd ? W'($urandom) : W'(r * 16 + c);
  endtask

  function automatic logic [W*NCOL-1:0] row_word(input int r);
    logic [W*NCOL-1:0] w;
    for (int c = 0; c < NCOL; c++) w[(NCOL-1-c)*W +: W] = mat[r][c];
    return w;
  endfunction

  // Reference: scatter every matrix element to its beat/core/element slot.
  task automatic build_expected();
    beat_t beats [NBEAT];
    int n, v, i, bb, h, j, k, e, b;
    for (int q = 0; q < NBEAT; q++) begin
      beats[q].data      = '0;
      beats[q].band_last = (q % 2 == 1);
      beats[q].last      = (q == NBEAT - 1);
    end
    for (int r = 0; r < NROW; r++) begin
      for (int c = 0; c < NCOL; c++) begin
        n = r / 4; v = (r % 4) / 2; i = r % 2;
        bb = c / 4; h = (c % 4) / 2; j = c % 2;
        k = v * 2 + h; e = i * 2 + j; b = n * 2 + bb;
        beats[b].data[((3-k)*4 + (3-e))*W +: W] = mat[r][c];
      end
    end
    exp_q.delete();
    for (int q = 0; q < NBEAT; q++) exp_q.push_back(beats[q]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_band_last", out_band_last, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    exp_q.delete();
    beats_seen = 0;
    rows_acc = 0;
    first_valid_edge = -1;
  endtask

  task automatic feed(input int nrows, input int duty);
    int r = 0;
    int guard = 0;
    bit acc;
    while (r < nrows && guard < 3000) begin
      in_data  = row_word(r);
      in_valid = ($urandom_range(99) < duty);
      @(negedge clk);
      acc = in_valid && in_ready && en;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_edge[r] = cyc;
        r++;
        rows_acc++;
      end
      guard++;
    end
    in_valid = 1'b0;
    check("feed_rows_accepted", r, nrows);
  endtask

  task automatic drain(input int duty);
    int guard = 0;
    while (beats_seen < NBEAT && guard < 3000) begin
      out_ready = ($urandom_range(99) < duty);
      @(posedge clk);
      #1;
      guard++;
    end
    out_ready = 1'b1;
    check("drain_beats", beats_seen, NBEAT);
  endtask

  task automatic end_checks();
    @(posedge clk);
    #1;
    check("end_done", done, 1);
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 0);
    check("end_queue_empty", exp_q.size(), 0);
  endtask

  // Every handshake is checked against the model; held beats must not change.
  always @(negedge clk) begin
    if (rst_n && out_valid && hold_prev) check("hold_stable", out_data, prev_data);
    if (rst_n && out_valid && first_valid_edge < 0) first_valid_edge = cyc;
    if (rst_n && en && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_beat: got %h expected no beat", out_data);
      end else begin
        cmp_e = exp_q.pop_front();
        check("beat_data", out_data, cmp_e.data);
        check("beat_band_last", out_band_last, cmp_e.band_last);
        check("beat_last", out_last, cmp_e.last);
        if (beats_seen == 0) first_data = out_data;
        beats_seen++;
      end
    end
    if (rst_n && done) check("done_quiet", {out_valid, in_ready}, 0);
    hold_prev = rst_n && out_valid && !(en && out_ready);
    prev_data = out_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic order and latency.
    fill_matrix(1'b0);
    do_reset();
    build_expected();
    check("model_beat0", exp_q[0].data, Lit0);
    check("model_beat1", exp_q[1].data, Lit1);
    check("model_beat2", exp_q[2].data, Lit2);
    fork
      feed(NROW, 100);
      drain(100);
    join
    end_checks();
    check("dut_beat0_literal", first_data, Lit0);
    check("latency_first_valid", first_valid_edge - acc_edge[3], 2);
    check("no_stall_rows4_7", acc_edge[7] - acc_edge[3], 4);

    // Back-pressure: both banks fill, beat 0 held.
    fill_matrix(1'b0);
    do_reset();
    build_expected();
    out_ready = 1'b0;
    fork
      feed(NROW, 100);
      begin
        int guard = 0;
        while (rows_acc < NROW && guard < 500) begin
          @(posedge clk);
          #1;
          guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_held_beat0", out_data, Lit0);
        drain(100);
      end
    join
    end_checks();

    // Input gaps with the regular matrix, then random data and random back-pressure.
    fill_matrix(1'b0);
    do_reset();
    build_expected();
    fork
      feed(NROW, 50);
      drain(100);
    join
    end_checks();
    for (int t = 0; t < 4; t++) begin
      fill_matrix(1'b1);
      do_reset();
      build_expected();
      fork
        feed(NROW, 50);
        drain(60);
      join
      end_checks();
    end

    // Enable freeze mid-band.
    fill_matrix(1'b1);
    do_reset();
    build_expected();
    fork
      feed(NROW, 100);
      drain(100);
      begin
        int guard = 0;
        while (rows_acc < 6 && guard < 500) begin
          @(posedge clk);
          #1;
          guard++;
        end
        en = 1'b0;
        snap = out_data;
        repeat (5) begin
          @(negedge clk);
          check("freeze_in_ready", in_ready, 0);
          check("freeze_out_data", out_data, snap);
        end
        @(posedge clk);
        #1;
        en = 1'b1;
      end
    join
    end_checks();

    // Mid-run reset after five rows, then a full clean run.
    fill_matrix(1'b0);
    do_reset();
    build_expected();
    feed(5, 100);
    do_reset();
    build_expected();
    fork
      feed(NROW, 100);
      drain(100);
    join
    end_checks();
    check("restart_beat0_literal", first_data, Lit0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
